pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline control for the 5-stage RV32 core.
- Consumes the ID-stage load-use hazard request (2-bit stall_and_flush), the EX-stage branch/jump redirect, and the IF/MEM bus-busy flags.
- Produces the per-stage stall and flush strobes and the PC write/redirect controls.
- Holds a redirect that arrives while an IF bus transaction is in flight, and keeps stall/flush performance counters.

Parameters:
ADDR_WIDTH, 32, PC/target address width
CNT_WIDTH, 32, width of performance counters

Ports:
clk_i  input  1  core clock
rst_ni  input  1  synchronous reset, active-low
hz_stall_and_flush_i  input  2  hazard request: bit1 = load-use stall, bit0 = flush; 2'b00 = none
br_taken_i  input  1  EX stage resolved redirect (branch taken / jump)
br_target_i  input  ADDR_WIDTH  redirect target, valid with br_taken_i
if_busy_i  input  1  IF bus transaction outstanding (fetch not complete this cycle)
mem_busy_i  input  1  MEM bus transaction outstanding
pc_we_o  output  1  PC register write enable
pc_redirect_o  output  1  PC takes pc_target_o instead of PC+4
pc_target_o  output  ADDR_WIDTH  redirect target
ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o  output  1 each  hold stage register
ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o  output  1 each  load bubble (NOP) into stage register
stall_cnt_o  output  CNT_WIDTH  cycles with pc_we_o=0 since reset
redirect_cnt_o  output  CNT_WIDTH  accepted redirects since reset

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low (rst_ni sampled on the clk_i rising edge).
- Reset (rst_ni=0 at the edge):
  - state <= IDLE, pend_target <= 0, both counters <= 0.
  - While rst_ni=0, outputs are forced to pc_we_o=0, pc_redirect_o=0, pc_target_o=0, all *_stall_o=0, all *_flush_o=1.
- States: IDLE, REDIR_PEND. Outputs are combinational from state and inputs, zero latency. Register updates take effect at the next edge.
- Priority in IDLE, highest first:
  1. mem_busy_i=1:
     - pc_we_o=0; ifid/idex/exmem_stall_o=1; memwb_flush_o=1.
     - br_taken_i and hz request are ignored, since EX is frozen and re-presents them.
  2. br_taken_i=1:
     - ifid_flush_o=1, idex_flush_o=1; pc_redirect_o=1, pc_target_o=br_target_i.
     - If if_busy_i=0: pc_we_o=1, stay IDLE.
     - If if_busy_i=1: pc_we_o=0, pend_target <= br_target_i, state <= REDIR_PEND.
     - redirect_cnt increments once, at acceptance.
     - Overrides any hz request.
  3. hz bit0=1 (flush, includes 2'b11): ifid_flush_o=1, idex_flush_o=1; pc_we_o=!if_busy_i, no redirect.
  4. hz=2'b10 (load-use): pc_we_o=0, ifid_stall_o=1, idex_flush_o=1 (bubble into EX), independent of if_busy_i.
  5. None of the above: pc_we_o=!if_busy_i; ifid_flush_o=if_busy_i (bubble while fetch pending).
- REDIR_PEND:
  - pc_redirect_o=1, pc_target_o=pend_target; ifid_flush_o=1 every cycle, discarding the wrong-path fetch.
  - pc_we_o=!if_busy_i. When if_busy_i=0: state <= IDLE.
  - A new br_taken_i is ignored; EX holds a bubble after the flush.
  - hz inputs are ignored. mem_busy_i=1 additionally asserts exmem_stall_o=1 and memwb_flush_o=1, without blocking the PC write.
- Strobe defaults: any stall/flush not listed is 0. A stage never has stall and flush both 1.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_we_o=0.
  - Both counters wrap modulo 2^CNT_WIDTH.
- Reset mid-REDIR_PEND: the pending target is discarded and the state returns to IDLE.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with br_taken_i=1 -> all flush_o=1, pc_we_o=0, counters 0. Release -> state IDLE, pc_we_o=1 with idle inputs.
- Load-use: hz=2'b10 for 1 cycle, if_busy_i=0 -> pc_we_o=0, ifid_stall_o=1, idex_flush_o=1; stall_cnt_o goes 0->1; next cycle pc_we_o=1.
- Redirect, fetch idle: br_taken_i=1, br_target_i=32'h8000_0040 -> same cycle pc_we_o=1, pc_redirect_o=1, pc_target_o=32'h8000_0040, ifid/idex_flush_o=1; redirect_cnt_o=1.
- Redirect during fetch: br_taken_i=1 (target 32'h8000_0100) with if_busy_i=1 for 3 more cycles -> REDIR_PEND for 3 cycles:
  - pc_target_o held at 32'h8000_0100, ifid_flush_o=1, pc_we_o=0.
  - pc_we_o=1 in the cycle if_busy_i drops, then IDLE; redirect_cnt_o incremented exactly once.
- MEM priority: mem_busy_i=1 together with br_taken_i=1 and hz=2'b10 for 2 cycles -> ifid/idex/exmem_stall_o=1, memwb_flush_o=1, no redirect, redirect_cnt unchanged; stall_cnt_o +2.
- Counter wrap: with CNT_WIDTH=4, 17 load-use cycles -> stall_cnt_o=1.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Bundle of the pipeline-control request inputs and stall/flush/PC outputs.
// The pipeline datapath drives through the master modport, and the
// controller sits on the slave modport.
interface pipe_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [1:0]            hz_stall_and_flush_i;
  logic                  br_taken_i;
  logic [ADDR_WIDTH-1:0] br_target_i;
  logic                  if_busy_i;
  logic                  mem_busy_i;
  logic                  pc_we_o;
  logic                  pc_redirect_o;
  logic [ADDR_WIDTH-1:0] pc_target_o;
  logic                  ifid_stall_o;
  logic                  idex_stall_o;
  logic                  exmem_stall_o;
  logic                  memwb_stall_o;
  logic                  ifid_flush_o;
  logic                  idex_flush_o;
  logic                  exmem_flush_o;
  logic                  memwb_flush_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;
  logic [CNT_WIDTH-1:0]  redirect_cnt_o;

  modport master (
    output hz_stall_and_flush_i, br_taken_i, br_target_i, if_busy_i, mem_busy_i,
    input  pc_we_o, pc_redirect_o, pc_target_o,
    input  ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o,
    input  ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
    input  stall_cnt_o, redirect_cnt_o
  );

  modport slave (
    input  hz_stall_and_flush_i, br_taken_i, br_target_i, if_busy_i, mem_busy_i,
    output pc_we_o, pc_redirect_o, pc_target_o,
    output ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o,
    output ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
    output stall_cnt_o, redirect_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline control for the 5-stage RV32 core: turns hazard, redirect
// and bus-busy requests into per-stage stall/flush strobes and PC controls.
// A redirect accepted while a fetch is in flight is parked in REDIR_PEND
// until the fetch completes. Stall and redirect counts are kept for perf.
module pipe_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [0:0] {IDLE = 1'b0, REDIR_PEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;
  logic [CNT_WIDTH-1:0]  redirect_cnt_q;

  logic                  pc_we_s;
  logic                  pc_redirect_s;
  logic [ADDR_WIDTH-1:0] pc_target_s;
  logic [3:0]            stall_s;   // {ifid, idex, exmem, memwb}
  logic [3:0]            flush_s;   // {ifid, idex, exmem, memwb}
  logic                  accept_s;  // redirect accepted this cycle

  // Output strobes and next-state selection from state and live requests
  always_comb begin
    pc_we_s       = 1'b0;
    pc_redirect_s = 1'b0;
    pc_target_s   = {ADDR_WIDTH{1'b0}};
    stall_s       = 4'b0000;
    flush_s       = 4'b0000;
    accept_s      = 1'b0;
    state_d       = state_q;
    pend_target_d = pend_target_q;
    if (!rst_ni) begin
      flush_s = 4'b1111;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mem_busy_i) begin
            // EX is frozen and will present branch/hazard again
            stall_s = 4'b1110;
            flush_s = 4'b0001;
          end else if (bus.br_taken_i) begin
            flush_s       = 4'b1100;
            pc_redirect_s = 1'b1;
            pc_target_s   = bus.br_target_i;
            accept_s      = 1'b1;
            if (bus.if_busy_i) begin
              pend_target_d = bus.br_target_i;
              state_d       = REDIR_PEND;
            end else begin
              pc_we_s = 1'b1;
            end
          end else if (bus.hz_stall_and_flush_i[0]) begin
            flush_s = 4'b1100;
            pc_we_s = !bus.if_busy_i;
          end else if (bus.hz_stall_and_flush_i[1]) begin
            // load-use: hold IF/ID, bubble into EX
            stall_s = 4'b1000;
            flush_s = 4'b0100;
          end else begin
            pc_we_s = !bus.if_busy_i;
            flush_s = {bus.if_busy_i, 3'b000};
          end
        end
        REDIR_PEND: begin
          // wrong-path fetch is discarded until the bus frees up
          pc_redirect_s = 1'b1;
          pc_target_s   = pend_target_q;
          pc_we_s       = !bus.if_busy_i;
          if (bus.mem_busy_i) begin
            stall_s = 4'b0010;
            flush_s = 4'b1001;
          end else begin
            flush_s = 4'b1000;
          end
          if (bus.if_busy_i) begin
            state_d = REDIR_PEND;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          flush_s = 4'b1111;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, pending target and performance counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      pend_target_q  <= {ADDR_WIDTH{1'b0}};
      stall_cnt_q    <= {CNT_WIDTH{1'b0}};
      redirect_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      if (!pc_we_s) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (accept_s) begin
        redirect_cnt_q <= redirect_cnt_q + CNT_WIDTH'(1);
      end else begin
        redirect_cnt_q <= redirect_cnt_q;
      end
    end
  end

  assign bus.pc_we_o        = pc_we_s;
  assign bus.pc_redirect_o  = pc_redirect_s;
  assign bus.pc_target_o    = pc_target_s;
  assign bus.ifid_stall_o   = stall_s[3];
  assign bus.idex_stall_o   = stall_s[2];
  assign bus.exmem_stall_o  = stall_s[1];
  assign bus.memwb_stall_o  = stall_s[0];
  assign bus.ifid_flush_o   = flush_s[3];
  assign bus.idex_flush_o   = flush_s[2];
  assign bus.exmem_flush_o  = flush_s[1];
  assign bus.memwb_flush_o  = flush_s[0];
  assign bus.stall_cnt_o    = stall_cnt_q;
  assign bus.redirect_cnt_o = redirect_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
// A second instance with 4-bit counters exercises counter wrap.
module tb_pipe_ctrl;
  logic        clk;
  logic        rst_n;
  logic [1:0]  hz;
  logic        br;
  logic [31:0] tgt;
  logic        ifb;
  logic        memb;

  int errors = 0;
  int checks = 0;

  pipe_ctrl_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) if32 ();
  pipe_ctrl_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4))  if4 ();

  assign if32.hz_stall_and_flush_i = hz;
  assign if32.br_taken_i           = br;
  assign if32.br_target_i          = tgt;
  assign if32.if_busy_i            = ifb;
  assign if32.mem_busy_i           = memb;
  assign if4.hz_stall_and_flush_i  = hz;
  assign if4.br_taken_i            = br;
  assign if4.br_target_i           = tgt;
  assign if4.if_busy_i             = ifb;
  assign if4.mem_busy_i            = memb;

  pipe_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk_i (clk), .rst_ni(rst_n), .bus(if32.slave));
  pipe_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk_i (clk), .rst_ni(rst_n), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pending redirect flag + target, plain counts
  typedef struct packed {
    logic        we;
    logic        red;
    logic [31:0] tgt;
    logic [3:0]  stall;  // {ifid, idex, exmem, memwb}
    logic [3:0]  flush;
  } exp_t;

  bit          m_pend = 1'b0;
  logic [31:0] m_ptgt = 32'h0;
  int unsigned m_scnt = 0;
  int unsigned m_rcnt = 0;
  bit          cnt_valid = 1'b0;
  exp_t        e;

  function automatic exp_t model_out();
    exp_t o;
    o = '0;
    if (!rst_n) begin
      o.flush = 4'b1111;
    end else if (m_pend) begin
      o.red = 1'b1; o.tgt = m_ptgt; o.flush[3] = 1'b1; o.we = !ifb;
      if (memb) begin o.stall[1] = 1'b1; o.flush[0] = 1'b1; end
    end else if (memb) begin
      o.stall = 4'b1110; o.flush = 4'b0001;
    end else if (br) begin
      o.flush = 4'b1100; o.red = 1'b1; o.tgt = tgt; o.we = !ifb;
    end else if (hz[0]) begin
      o.flush = 4'b1100; o.we = !ifb;
    end else if (hz == 2'b10) begin
      o.stall = 4'b1000; o.flush = 4'b0100;
    end else begin
      o.we = !ifb; o.flush[3] = ifb;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance model at posedge
  task automatic step(input logic r, input logic [1:0] h, input logic b,
                      input logic [31:0] t, input logic ib, input logic mb);
    logic [3:0] st, fl;
    @(negedge clk);
    rst_n = r; hz = h; br = b; tgt = t; ifb = ib; memb = mb;
    #1;
    e  = model_out();
    st = {if32.ifid_stall_o, if32.idex_stall_o, if32.exmem_stall_o, if32.memwb_stall_o};
    fl = {if32.ifid_flush_o, if32.idex_flush_o, if32.exmem_flush_o, if32.memwb_flush_o};
    chk("pc_we", 64'(if32.pc_we_o), 64'(e.we));
    chk("pc_redirect", 64'(if32.pc_redirect_o), 64'(e.red));
    chk("pc_target", 64'(if32.pc_target_o), 64'(e.tgt));
    chk("stalls", 64'(st), 64'(e.stall));
    chk("flushes", 64'(fl), 64'(e.flush));
    chk("stall_and_flush_overlap", 64'(st & fl), 64'h0);
    chk("pc_we_cnt4", 64'(if4.pc_we_o), 64'(e.we));
    if (cnt_valid) begin
      chk("stall_cnt", 64'(if32.stall_cnt_o), 64'(m_scnt));
      chk("redirect_cnt", 64'(if32.redirect_cnt_o), 64'(m_rcnt));
      chk("stall_cnt4", 64'(if4.stall_cnt_o), 64'(m_scnt % 16));
      chk("redirect_cnt4", 64'(if4.redirect_cnt_o), 64'(m_rcnt % 16));
    end
    @(posedge clk);
    if (!r) begin
      m_pend = 1'b0; m_ptgt = 32'h0; m_scnt = 0; m_rcnt = 0; cnt_valid = 1'b1;
    end else begin
      if (!e.we) m_scnt++;
      if (!m_pend && !mb && b) begin
        m_rcnt++;
        if (ib) begin m_pend = 1'b1; m_ptgt = t; end
      end else if (m_pend && !ib) begin
        m_pend = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; hz = 2'b00; br = 1'b0; tgt = 32'h0; ifb = 1'b0; memb = 1'b0;

    // Reset held 3 cycles with a redirect request present
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b1, 32'hDEAD_BEE0, 1'b0, 1'b0);
    chk("rst_flush_lit", 64'(if32.ifid_flush_o & if32.memwb_flush_o), 64'h1);
    // Release with idle inputs
    step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("release_we_lit", 64'(if32.pc_we_o), 64'h1);
    chk("release_cnt_lit", 64'(if32.stall_cnt_o), 64'h0);

    // Load-use, fetch idle
    step(1'b1, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("lu_we_lit", 64'(if32.pc_we_o), 64'h0);
    chk("lu_stall_lit", 64'(if32.ifid_stall_o), 64'h1);
    chk("lu_flush_lit", 64'(if32.idex_flush_o), 64'h1);
    step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("lu_cnt_lit", 64'(if32.stall_cnt_o), 64'h1);
    chk("lu_next_we_lit", 64'(if32.pc_we_o), 64'h1);

    // Redirect with fetch idle
    step(1'b1, 2'b00, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
    chk("redir_tgt_lit", 64'(if32.pc_target_o), 64'h8000_0040);
    chk("redir_we_lit", 64'(if32.pc_we_o), 64'h1);
    step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("redir_cnt_lit", 64'(if32.redirect_cnt_o), 64'h1);

    // Redirect during fetch: accepted, then 3 pending cycles, then drop
    step(1'b1, 2'b00, 1'b1, 32'h8000_0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b01, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
      chk("pend_tgt_lit", 64'(if32.pc_target_o), 64'h8000_0100);
      chk("pend_we_lit", 64'(if32.pc_we_o), 64'h0);
      chk("pend_ifid_flush_lit", 64'(if32.ifid_flush_o), 64'h1);
    end
    step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pend_drop_we_lit", 64'(if32.pc_we_o), 64'h1);
    step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pend_redir_cnt_lit", 64'(if32.redirect_cnt_o), 64'h2);
    chk("pend_idle_redirect_lit", 64'(if32.pc_redirect_o), 64'h0);

    // MEM busy has priority over redirect and load-use
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'b10, 1'b1, 32'h8000_0200, 1'b0, 1'b1);
      chk("mem_redirect_lit", 64'(if32.pc_redirect_o), 64'h0);
    end
    step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mem_redir_cnt_lit", 64'(if32.redirect_cnt_o), 64'h2);

    // Counter wrap: 17 load-use cycles after a fresh reset
    step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("wrap_cnt4_lit", 64'(if4.stall_cnt_o), 64'h1);
    chk("wrap_cnt32_lit", 64'(if32.stall_cnt_o), 64'd17);

    // Randomized traffic, including occasional reset mid-operation
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0),
           $urandom(),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
